capp_cell_array: RTL

Storage-and-tag array of the content-addressable parallel processor; sits directly downstream of `compare` and consumes its `mismatch_lines` broadcast. It holds `num_cells` words of `num_bits` each, plus one tag (responder) bit per cell. On a search it clears the tag of every cell whose stored word conflicts with an asserted mismatch line. It also supports addressed read/write, parallel write to all tagged cells, tag set-all and first-responder select, and publishes registered responder status.

---
 rtl/capp_cell_array.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/capp_cell_array.sv
// capp_cell_array
// Storage-and-tag array of the content-addressable parallel processor.
// Each of num_cells cells holds a num_bits word and a tag (responder) bit.
// A SEARCH clears the tag of every cell whose word conflicts with an asserted
// mismatch line coming from the upstream comparator.
//
// Ports:
//   CLK, RST_N      clock, asynchronous active-low reset
//   mismatch_lines  2*num_bits; bit 2i rejects cells with bit i = 0,
//                   bit 2i+1 rejects cells with bit i = 1
//   cmd_valid, cmd  command strobe and opcode
//                   (0 NOP, 1 WRITE, 2 READ, 3 SEARCH, 4 SET_TAGS,
//                    5 SELECT_FIRST, 6 WRITE_TAGGED, 7 NOP)
//   cmd_addr        cell address for WRITE / READ
//   cmd_data        write data for WRITE / WRITE_TAGGED
//   cmd_ready       high when a command can be accepted
//   rd_data         READ result, qualified by the one-cycle rd_valid pulse
//   tags            current tag bits
//   some_responder  registered: at least one tag set
//   first_addr      registered: lowest tagged index, 0 if none
//   resp_count      registered: number of tags set
module capp_cell_array #(
    parameter int num_bits  = 32,
    parameter int num_cells = 100,
    parameter int addr_bits = 7,
    parameter int cnt_bits  = 7
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [2*num_bits-1:0]   mismatch_lines,
    input  logic                    cmd_valid,
    input  logic [2:0]              cmd,
    input  logic [addr_bits-1:0]    cmd_addr,
    input  logic [num_bits-1:0]     cmd_data,
    output logic                    cmd_ready,
    output logic [num_bits-1:0]     rd_data,
    output logic                    rd_valid,
    output logic [num_cells-1:0]    tags,
    output logic                    some_responder,
    output logic [addr_bits-1:0]    first_addr,
    output logic [cnt_bits-1:0]     resp_count
);

    localparam logic [2:0] OP_WRITE        = 3'd1;
    localparam logic [2:0] OP_READ         = 3'd2;
    localparam logic [2:0] OP_SEARCH       = 3'd3;
    localparam logic [2:0] OP_SET_TAGS     = 3'd4;
    localparam logic [2:0] OP_SELECT_FIRST = 3'd5;
    localparam logic [2:0] OP_WRITE_TAGGED = 3'd6;

    localparam logic [addr_bits:0] cell_lim = (addr_bits+1)'(num_cells);

    typedef enum logic {IDLE, UPD} state_t;

    state_t                 state_q, state_d;
    logic [num_bits-1:0]    word [num_cells];
    logic [num_cells-1:0]   tag_q;
    logic                   accept;
    logic                   tag_cmd;
    logic                   addr_ok;
    logic [num_bits-1:0]    ml_zero, ml_one;
    logic [num_cells-1:0]   mismatch;
    logic [num_cells-1:0]   sel_vec;
    logic [addr_bits-1:0]   first_d;
    logic [cnt_bits-1:0]    cnt_d;

    assign tags      = tag_q;
    assign cmd_ready = (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign addr_ok   = {1'b0, cmd_addr} < cell_lim;
    assign tag_cmd   = (cmd == OP_SEARCH) || (cmd == OP_SET_TAGS) ||
                       (cmd == OP_SELECT_FIRST);

    // Tag-changing commands spend one UPD cycle so the status registers
    // catch up before the next command can consume them.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && tag_cmd) state_d = UPD;
            UPD:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // De-interleave the mismatch lines into "reject zero" / "reject one" masks.
    always_comb begin
        ml_zero = '0;
        ml_one  = '0;
        for (int j = 0; j < num_bits; j++) begin
            ml_zero[j] = mismatch_lines[2*j];
            ml_one[j]  = mismatch_lines[2*j+1];
        end
    end

    always_comb begin
        mismatch = '0;
        for (int c = 0; c < num_cells; c++)
            mismatch[c] = |((ml_zero & ~word[c]) | (ml_one & word[c]));
    end

    // Priority encode (lowest index wins) and population count of the tags.
    always_comb begin
        first_d = '0;
        cnt_d   = '0;
        for (int c = num_cells - 1; c >= 0; c--)
            if (tag_q[c]) first_d = addr_bits'(c);
        for (int c = 0; c < num_cells; c++)
            cnt_d = cnt_d + cnt_bits'(tag_q[c]);
    end

    // SELECT_FIRST uses the registered status, which is settled because the
    // preceding tag command went through UPD.
    assign sel_vec = some_responder ? (num_cells'(1) << first_addr) : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tag_q <= '0;
        end else if (accept) begin
            case (cmd)
                OP_SEARCH:       tag_q <= tag_q & ~mismatch;
                OP_SET_TAGS:     tag_q <= '1;
                OP_SELECT_FIRST: tag_q <= sel_vec;
                default:         tag_q <= tag_q;
            endcase
        end
    end

    // Out-of-range WRITE addresses match no cell and are dropped.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int c = 0; c < num_cells; c++) word[c] <= '0;
        end else if (accept) begin
            for (int c = 0; c < num_cells; c++) begin
                if (cmd == OP_WRITE_TAGGED && tag_q[c])
                    word[c] <= cmd_data;
                else if (cmd == OP_WRITE && cmd_addr == addr_bits'(c))
                    word[c] <= cmd_data;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= accept && (cmd == OP_READ);
            if (accept && cmd == OP_READ)
                rd_data <= addr_ok ? word[cmd_addr] : '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            some_responder <= 1'b0;
            first_addr     <= '0;
            resp_count     <= '0;
        end else begin
            some_responder <= |tag_q;
            first_addr     <= first_d;
            resp_count     <= cnt_d;
        end
    end

endmodule
